// File: rtl/bus_datapath_seq.sv
// Single-bus datapath with its own micro-op sequencer.
// One bus transfer or memory command per cmd_valid/cmd_ready handshake.
//
// Ports:
//   clock, clear        rising-edge clock, synchronous active-high reset
//   cmd_*               command handshake and fields; cmd_done/cmd_err pulse
//   mem_*               memory request/ack port (wait states tolerated)
//   in_port, out_port   sampled input register, OUT register
//   ir_out              IR contents for the decoder
//
// Build option: define DATAPATH_MUL_EN to add the Booth multiplier (ALU op B).
module bus_datapath_seq #(
    parameter  int DATA_W   = 32,
    parameter  int NUM_REGS = 16,
    parameter  int MEM_AW   = 9,
    localparam int RW       = $clog2(NUM_REGS),
    localparam int SRC_W    = RW + 3
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [SRC_W-1:0]  cmd_src,
    input  logic [DATA_W-1:0] cmd_const,
    input  logic              cmd_ba,
    input  logic              cmd_dst_en,
    input  logic [RW-1:0]     cmd_dst_reg,
    input  logic [8:0]        cmd_dst_misc,
    input  logic [3:0]        cmd_alu_op,
    input  logic              cmd_inc_pc,
    input  logic [1:0]        cmd_mem,
    output logic              cmd_done,
    output logic              cmd_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] in_port,
    output logic [DATA_W-1:0] out_port,
    output logic [DATA_W-1:0] ir_out
);

    localparam int SH_W = $clog2(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_XFER = 3'd1,
`ifdef DATAPATH_MUL_EN
        S_MUL  = 3'd2,
`endif
        S_MEM  = 3'd3,
        S_ERR  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t r_state;
    state_t w_state_n;

    // latched command fields
    logic [SRC_W-1:0]  r_src;
    logic [DATA_W-1:0] r_const;
    logic              r_ba;
    logic              r_dst_en;
    logic [RW-1:0]     r_dst_reg;
    logic [8:0]        r_misc;
    logic [3:0]        r_op;
    logic              r_inc;
    logic [1:0]        r_mem;
    logic              r_err;

    // architectural registers
    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [DATA_W-1:0] r_y, r_zhi, r_zlo, r_hi, r_lo, r_pc;
    logic [DATA_W-1:0] r_mdr, r_ir, r_out, r_inport;
    logic [MEM_AW-1:0] r_mar;

    logic [DATA_W-1:0] w_bus;
    logic [SRC_W-1:0]  w_code;
    logic [DATA_W-1:0] w_zhi, w_zlo;
    logic [DATA_W:0]   w_add, w_sub;
    logic [SH_W-1:0]   w_amt;
    logic [SH_W:0]     w_inv;
    logic              w_is_mul;

    assign w_is_mul = (r_op == 4'hB) && r_misc[3];

    // bus source select; codes past CONST drive 0
    assign w_code = r_src - SRC_W'(NUM_REGS);

    always_comb begin
        w_bus = '0;
        if (r_src < SRC_W'(NUM_REGS)) begin
            if (!(r_ba && (r_src == '0)))
                w_bus = r_regs[r_src[RW-1:0]];
        end else begin
            unique case (w_code)
                SRC_W'(0): w_bus = r_hi;
                SRC_W'(1): w_bus = r_lo;
                SRC_W'(2): w_bus = r_zhi;
                SRC_W'(3): w_bus = r_zlo;
                SRC_W'(4): w_bus = r_pc;
                SRC_W'(5): w_bus = r_mdr;
                SRC_W'(6): w_bus = r_inport;
                SRC_W'(7): w_bus = r_const;
                default:   w_bus = '0;
            endcase
        end
    end

    // ALU, A = Y, B = bus
    assign w_add = {1'b0, r_y} + {1'b0, w_bus};
    assign w_sub = {1'b0, r_y} - {1'b0, w_bus};
    assign w_amt = w_bus[SH_W-1:0];
    // complementary shift for rotates; amt 0 gives a shift of DATA_W -> 0
    assign w_inv = (SH_W+1)'(DATA_W) - {1'b0, w_amt};

    always_comb begin
        w_zhi = '0;
        w_zlo = '0;
        unique case (r_op)
            4'h0: begin
                w_zlo = w_add[DATA_W-1:0];
                w_zhi = DATA_W'(w_add[DATA_W]);
            end
            4'h1: begin
                w_zlo = w_sub[DATA_W-1:0];
                w_zhi = DATA_W'(w_sub[DATA_W]);
            end
            4'h2: w_zlo = r_y & w_bus;
            4'h3: w_zlo = r_y | w_bus;
            4'h4: w_zlo = r_y >> w_amt;
            4'h5: w_zlo = $signed(r_y) >>> w_amt;
            4'h6: w_zlo = r_y << w_amt;
            4'h7: w_zlo = (r_y >> w_amt) | (r_y << w_inv);
            4'h8: w_zlo = (r_y << w_amt) | (r_y >> w_inv);
            4'h9: w_zlo = ~w_bus + DATA_W'(1);
            4'hA: w_zlo = ~w_bus;
            4'hB: w_zlo = '0;
            default: w_zlo = w_bus;
        endcase
    end

`ifdef DATAPATH_MUL_EN
    // radix-2 Booth: A is one bit wider so subtracting the most
    // negative multiplicand cannot overflow
    localparam int CNT_W = SH_W;
    logic [DATA_W:0]   r_mul_a, r_mul_m, w_mul_s, w_mul_a;
    logic [DATA_W-1:0] r_mul_q, w_mul_q;
    logic              r_mul_q1;
    logic [CNT_W-1:0]  r_mul_cnt;

    always_comb begin
        w_mul_s = r_mul_a;
        if (r_mul_q[0] && !r_mul_q1)
            w_mul_s = r_mul_a - r_mul_m;
        else if (!r_mul_q[0] && r_mul_q1)
            w_mul_s = r_mul_a + r_mul_m;
    end

    assign w_mul_a = {w_mul_s[DATA_W], w_mul_s[DATA_W:1]};
    assign w_mul_q = {w_mul_s[0], r_mul_q[DATA_W-1:1]};
`endif

    always_comb begin
        w_state_n = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_mem == 2'b00)
                        w_state_n = S_XFER;
                    else if (cmd_mem == 2'b11)
                        w_state_n = S_ERR;
                    else
                        w_state_n = S_MEM;
                end
            end
            S_XFER: begin
                w_state_n = S_DONE;
`ifdef DATAPATH_MUL_EN
                if (w_is_mul)
                    w_state_n = S_MUL;
`endif
            end
`ifdef DATAPATH_MUL_EN
            S_MUL: begin
                if (r_mul_cnt == CNT_W'(DATA_W - 1))
                    w_state_n = S_DONE;
            end
`endif
            S_MEM: begin
                if (mem_ack)
                    w_state_n = S_DONE;
            end
            S_ERR:   w_state_n = S_DONE;
            S_DONE:  w_state_n = S_IDLE;
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear)
            r_state <= S_IDLE;
        else
            r_state <= w_state_n;
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_src     <= '0;
            r_const   <= '0;
            r_ba      <= 1'b0;
            r_dst_en  <= 1'b0;
            r_dst_reg <= '0;
            r_misc    <= '0;
            r_op      <= '0;
            r_inc     <= 1'b0;
            r_mem     <= '0;
            r_err     <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++)
                r_regs[i] <= '0;
            r_y      <= '0;
            r_zhi    <= '0;
            r_zlo    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_pc     <= '0;
            r_mar    <= '0;
            r_mdr    <= '0;
            r_ir     <= '0;
            r_out    <= '0;
            r_inport <= '0;
`ifdef DATAPATH_MUL_EN
            r_mul_a   <= '0;
            r_mul_m   <= '0;
            r_mul_q   <= '0;
            r_mul_q1  <= 1'b0;
            r_mul_cnt <= '0;
`endif
        end else begin
            r_inport <= in_port;

            if ((r_state == S_IDLE) && cmd_valid) begin
                r_src     <= cmd_src;
                r_const   <= cmd_const;
                r_ba      <= cmd_ba;
                r_dst_en  <= cmd_dst_en;
                r_dst_reg <= cmd_dst_reg;
                r_misc    <= cmd_dst_misc;
                r_op      <= cmd_alu_op;
                r_inc     <= cmd_inc_pc;
                r_mem     <= cmd_mem;
                r_err     <= (cmd_mem == 2'b11);
            end

            if (r_state == S_XFER) begin
                if (r_dst_en)   r_regs[r_dst_reg] <= w_bus;
                if (r_misc[0])  r_y   <= w_bus;
                if (r_misc[1])  r_hi  <= w_bus;
                if (r_misc[2])  r_lo  <= w_bus;
                if (r_misc[4])  r_pc  <= w_bus;
                else if (r_inc) r_pc  <= r_pc + DATA_W'(1);
                if (r_misc[5])  r_mar <= w_bus[MEM_AW-1:0];
                if (r_misc[6])  r_mdr <= w_bus;
                if (r_misc[7])  r_ir  <= w_bus;
                if (r_misc[8])  r_out <= w_bus;
`ifdef DATAPATH_MUL_EN
                if (w_is_mul) begin
                    r_mul_a   <= '0;
                    r_mul_m   <= {r_y[DATA_W-1], r_y};
                    r_mul_q   <= w_bus;
                    r_mul_q1  <= 1'b0;
                    r_mul_cnt <= '0;
                end else if (r_misc[3]) begin
                    r_zhi <= w_zhi;
                    r_zlo <= w_zlo;
                end
`else
                if (r_misc[3]) begin
                    r_zhi <= w_zhi;
                    r_zlo <= w_zlo;
                end
                if (w_is_mul)
                    r_err <= 1'b1;
`endif
            end

`ifdef DATAPATH_MUL_EN
            if (r_state == S_MUL) begin
                r_mul_a   <= w_mul_a;
                r_mul_q   <= w_mul_q;
                r_mul_q1  <= r_mul_q[0];
                r_mul_cnt <= r_mul_cnt + CNT_W'(1);
                if (r_mul_cnt == CNT_W'(DATA_W - 1)) begin
                    r_zhi <= w_mul_a[DATA_W-1:0];
                    r_zlo <= w_mul_q;
                end
            end
`endif

            if ((r_state == S_MEM) && mem_ack && (r_mem == 2'b01))
                r_mdr <= mem_rdata;
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign cmd_done  = (r_state == S_DONE);
    assign cmd_err   = (r_state == S_DONE) && r_err;
    assign mem_req   = (r_state == S_MEM);
    assign mem_we    = (r_state == S_MEM) && (r_mem == 2'b10);
    assign mem_addr  = r_mar;
    assign mem_wdata = r_mdr;
    assign out_port  = r_out;
    assign ir_out    = r_ir;

endmodule

// File: tb/tb_bus_datapath_seq.sv
// Directed testbench for bus_datapath_seq (default parameters).
// Each task drives one scenario and checks its own expected values.
module tb_bus_datapath_seq;

    localparam logic [6:0] S_HI = 7'd16, S_LO = 7'd17, S_ZHI = 7'd18;
    localparam logic [6:0] S_ZLO = 7'd19, S_PC = 7'd20, S_MDR = 7'd21;
    localparam logic [6:0] S_IN = 7'd22, S_K = 7'd23;
    localparam logic [8:0] M_OUT = 9'h100, M_IR = 9'h080, M_MDR = 9'h040;
    localparam logic [8:0] M_MAR = 9'h020, M_PC = 9'h010, M_Z = 9'h008;
    localparam logic [8:0] M_Y = 9'h001, M_NONE = 9'h000;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [6:0]  cmd_src = '0;
    logic [31:0] cmd_const = '0;
    logic        cmd_ba = 1'b0;
    logic        cmd_dst_en = 1'b0;
    logic [3:0]  cmd_dst_reg = '0;
    logic [8:0]  cmd_dst_misc = '0;
    logic [3:0]  cmd_alu_op = '0;
    logic        cmd_inc_pc = 1'b0;
    logic [1:0]  cmd_mem = '0;
    logic        cmd_done, cmd_err;
    logic        mem_req, mem_we;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] in_port = '0;
    logic [31:0] out_port, ir_out;

    int n_checks = 0;
    int n_fail = 0;

    bus_datapath_seq dut (
        .clock(clock), .clear(clear),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src(cmd_src), .cmd_const(cmd_const), .cmd_ba(cmd_ba),
        .cmd_dst_en(cmd_dst_en), .cmd_dst_reg(cmd_dst_reg),
        .cmd_dst_misc(cmd_dst_misc), .cmd_alu_op(cmd_alu_op),
        .cmd_inc_pc(cmd_inc_pc), .cmd_mem(cmd_mem),
        .cmd_done(cmd_done), .cmd_err(cmd_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .in_port(in_port), .out_port(out_port), .ir_out(ir_out)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // offer one command; returns one cycle after the accept edge
    task automatic drive(input logic [6:0] src, input logic [31:0] k,
                         input logic ba, input logic den,
                         input logic [3:0] dreg, input logic [8:0] misc,
                         input logic [3:0] op, input logic inc,
                         input logic [1:0] mem);
        cmd_src = src; cmd_const = k; cmd_ba = ba;
        cmd_dst_en = den; cmd_dst_reg = dreg; cmd_dst_misc = misc;
        cmd_alu_op = op; cmd_inc_pc = inc; cmd_mem = mem;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    // lat = cycles from accept edge to the done cycle, -1 on timeout
    task automatic wait_done(output int lat, output logic err);
        int n;
        n = 0;
        lat = -1;
        err = 1'b0;
        while (cmd_done !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        if (cmd_done === 1'b1) begin
            lat = n + 1;
            err = cmd_err;
        end
        step();
    endtask

    task automatic xf(input logic [6:0] src, input logic [31:0] k,
                      input logic den, input logic [3:0] dreg,
                      input logic [8:0] misc, input logic [3:0] op,
                      output int lat, output logic err);
        drive(src, k, 1'b0, den, dreg, misc, op, 1'b0, 2'b00);
        wait_done(lat, err);
    endtask

    task automatic test_reset();
        clear = 1'b1;
        step();
        step();
        clear = 1'b0;
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
        n_checks++; if (out_port !== 32'h0) begin n_fail++; $display("FAIL reset_out: got %h want 0", out_port); end
        n_checks++; if (ir_out !== 32'h0) begin n_fail++; $display("FAIL reset_ir: got %h want 0", ir_out); end
        n_checks++; if (mem_req !== 1'b0 || cmd_done !== 1'b0) begin n_fail++; $display("FAIL reset_ctl: req %b done %b want 0 0", mem_req, cmd_done); end
    endtask

    task automatic test_transfer();
        int lat;
        logic err;
        xf(S_K, 32'h5, 1'b1, 4'd3, M_NONE, 4'hC, lat, err);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL xfer_lat1: got %0d want 2", lat); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL xfer_ready: got %b want 1", cmd_ready); end
        xf(7'd3, 32'h0, 1'b0, 4'd0, M_OUT, 4'hC, lat, err);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL xfer_lat2: got %0d want 2", lat); end
        n_checks++; if (out_port !== 32'h5) begin n_fail++; $display("FAIL xfer_r3_out: got %h want 5", out_port); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL xfer_err: got %b want 0", err); end
        in_port = 32'hCAFE_0001;
        step();
        xf(S_IN, 32'h0, 1'b0, 4'd0, M_OUT, 4'hC, lat, err);
        n_checks++; if (out_port !== 32'hCAFE_0001) begin n_fail++; $display("FAIL xfer_inport: got %h want cafe0001", out_port); end
        xf(S_K, 32'h1234, 1'b0, 4'd0, M_OUT | M_IR | M_PC, 4'hC, lat, err);
        n_checks++; if (ir_out !== 32'h1234 || out_port !== 32'h1234) begin n_fail++; $display("FAIL xfer_multi: ir %h out %h want 1234 1234", ir_out, out_port); end
        drive(S_K, 32'h0, 1'b0, 1'b0, 4'd0, M_NONE, 4'hC, 1'b1, 2'b00);
        wait_done(lat, err);
        xf(S_PC, 32'h0, 1'b0, 4'd0, M_OUT, 4'hC, lat, err);
        n_checks++; if (out_port !== 32'h1235) begin n_fail++; $display("FAIL xfer_incpc: got %h want 1235", out_port); end
        drive(S_K, 32'h40, 1'b0, 1'b0, 4'd0, M_PC, 4'hC, 1'b1, 2'b00);
        wait_done(lat, err);
        xf(S_PC, 32'h0, 1'b0, 4'd0, M_OUT, 4'hC, lat, err);
        n_checks++; if (out_port !== 32'h40) begin n_fail++; $display("FAIL xfer_pcload_wins: got %h want 40", out_port); end
    endtask

    task automatic alu_case(input string name, input logic [31:0] y,
                            input logic [31:0] b, input logic [3:0] op,
                            input logic [31:0] exp_lo,
                            input logic [31:0] exp_hi);
        int lat;
        logic err;
        xf(S_K, y, 1'b0, 4'd0, M_Y, 4'hC, lat, err);
        xf(S_K, b, 1'b0, 4'd0, M_Z, op, lat, err);
        xf(S_ZLO, 32'h0, 1'b0, 4'd0, M_OUT, 4'hC, lat, err);
        n_checks++; if (out_port !== exp_lo) begin n_fail++; $display("FAIL alu_%s_lo: got %h want %h", name, out_port, exp_lo); end
        xf(S_ZHI, 32'h0, 1'b0, 4'd0, M_OUT, 4'hC, lat, err);
        n_checks++; if (out_port !== exp_hi) begin n_fail++; $display("FAIL alu_%s_hi: got %h want %h", name, out_port, exp_hi); end
    endtask

    task automatic test_alu();
        alu_case("sub", 32'd7, 32'd3, 4'h1, 32'h4, 32'h0);
        alu_case("sub_borrow", 32'd7, 32'd9, 4'h1, 32'hFFFF_FFFE, 32'h1);
        alu_case("add_carry", 32'hFFFF_FFFF, 32'h2, 4'h0, 32'h1, 32'h1);
        alu_case("and", 32'hF0F0_1234, 32'h0FF0_FF00, 4'h2, 32'h00F0_1200, 32'h0);
        alu_case("shra", 32'h8000_0000, 32'd4, 4'h5, 32'hF800_0000, 32'h0);
        alu_case("shr_wrap", 32'h8000_0000, 32'd36, 4'h4, 32'h0800_0000, 32'h0);
        alu_case("ror", 32'h0000_0003, 32'd1, 4'h7, 32'h8000_0001, 32'h0);
        alu_case("rol", 32'h8000_0001, 32'd4, 4'h8, 32'h0000_0018, 32'h0);
        alu_case("neg", 32'h0, 32'd1, 4'h9, 32'hFFFF_FFFF, 32'h0);
    endtask

    task automatic test_ba();
        int lat;
        logic err;
        xf(S_K, 32'h55, 1'b1, 4'd0, M_NONE, 4'hC, lat, err);
        drive(7'd0, 32'h0, 1'b1, 1'b1, 4'd1, M_NONE, 4'hC, 1'b0, 2'b00);
        wait_done(lat, err);
        xf(7'd1, 32'h0, 1'b0, 4'd0, M_OUT, 4'hC, lat, err);
        n_checks++; if (out_port !== 32'h0) begin n_fail++; $display("FAIL ba_set: got %h want 0", out_port); end
        drive(7'd0, 32'h0, 1'b0, 1'b1, 4'd1, M_NONE, 4'hC, 1'b0, 2'b00);
        wait_done(lat, err);
        xf(7'd1, 32'h0, 1'b0, 4'd0, M_OUT, 4'hC, lat, err);
        n_checks++; if (out_port !== 32'h55) begin n_fail++; $display("FAIL ba_clr: got %h want 55", out_port); end
    endtask

    task automatic test_mem_read();
        int lat;
        int reqs;
        logic err;
        xf(S_K, 32'h1F0, 1'b0, 4'd0, M_MAR, 4'hC, lat, err);
        drive(S_K, 32'h0, 1'b0, 1'b0, 4'd0, M_NONE, 4'hC, 1'b0, 2'b01);
        n_checks++; if (mem_addr !== 9'h1F0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL memrd_addr: addr %h we %b want 1f0 0", mem_addr, mem_we); end
        reqs = 0;
        for (int i = 0; i < 3; i++) begin
            if (mem_req === 1'b1) reqs++;
            if (i == 2) begin
                mem_ack = 1'b1;
                mem_rdata = 32'hDEAD_BEEF;
            end
            step();
            mem_ack = 1'b0;
        end
        n_checks++; if (reqs !== 3) begin n_fail++; $display("FAIL memrd_reqs: got %0d want 3", reqs); end
        n_checks++; if (cmd_done !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL memrd_done: done %b req %b want 1 0", cmd_done, mem_req); end
        step();
        xf(S_MDR, 32'h0, 1'b0, 4'd0, M_OUT, 4'hC, lat, err);
        n_checks++; if (out_port !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL memrd_mdr: got %h want deadbeef", out_port); end
    endtask

    task automatic test_mem_write();
        int lat;
        logic err;
        xf(S_K, 32'hA5, 1'b0, 4'd0, M_MDR, 4'hC, lat, err);
        xf(S_K, 32'h3, 1'b0, 4'd0, M_MAR, 4'hC, lat, err);
        drive(S_K, 32'h0, 1'b0, 1'b0, 4'd0, M_NONE, 4'hC, 1'b0, 2'b10);
        n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'hA5 || mem_addr !== 9'h3) begin n_fail++; $display("FAIL memwr_bus: req %b we %b wd %h a %h want 1 1 a5 3", mem_req, mem_we, mem_wdata, mem_addr); end
        mem_ack = 1'b1;
        mem_rdata = 32'h1111_1111;
        step();
        mem_ack = 1'b0;
        n_checks++; if (cmd_done !== 1'b1) begin n_fail++; $display("FAIL memwr_done: got %b want 1", cmd_done); end
        step();
        xf(S_MDR, 32'h0, 1'b0, 4'd0, M_OUT, 4'hC, lat, err);
        n_checks++; if (out_port !== 32'hA5) begin n_fail++; $display("FAIL memwr_mdr_kept: got %h want a5", out_port); end
    endtask

    task automatic test_err();
        int lat;
        logic err;
        drive(S_K, 32'h77, 1'b0, 1'b0, 4'd0, M_OUT, 4'hC, 1'b0, 2'b11);
        wait_done(lat, err);
        n_checks++; if (lat !== 2 || err !== 1'b1) begin n_fail++; $display("FAIL err_cmd: lat %0d err %b want 2 1", lat, err); end
        n_checks++; if (out_port !== 32'hA5) begin n_fail++; $display("FAIL err_nochange: got %h want a5", out_port); end
    endtask

    task automatic test_mul();
        int lat;
        logic err;
        logic [31:0] zlo, zhi;
        xf(S_K, 32'hFFFF_FFFD, 1'b0, 4'd0, M_Y, 4'hC, lat, err);
        xf(S_K, 32'd6, 1'b0, 4'd0, M_Z, 4'hB, lat, err);
`ifdef DATAPATH_MUL_EN
        n_checks++; if (lat !== 34 || err !== 1'b0) begin n_fail++; $display("FAIL mul_lat: lat %0d err %b want 34 0", lat, err); end
        zlo = 32'hFFFF_FFEE;
        zhi = 32'hFFFF_FFFF;
`else
        n_checks++; if (lat !== 2 || err !== 1'b1) begin n_fail++; $display("FAIL mul_off: lat %0d err %b want 2 1", lat, err); end
        zlo = 32'h0;
        zhi = 32'h0;
`endif
        xf(S_ZLO, 32'h0, 1'b0, 4'd0, M_OUT, 4'hC, lat, err);
        n_checks++; if (out_port !== zlo) begin n_fail++; $display("FAIL mul_zlo: got %h want %h", out_port, zlo); end
        xf(S_ZHI, 32'h0, 1'b0, 4'd0, M_OUT, 4'hC, lat, err);
        n_checks++; if (out_port !== zhi) begin n_fail++; $display("FAIL mul_zhi: got %h want %h", out_port, zhi); end
    endtask

    task automatic test_clear_mid();
        int lat;
        int dones;
        logic err;
        xf(S_K, 32'h77, 1'b0, 4'd0, M_MDR | M_OUT, 4'hC, lat, err);
        drive(S_K, 32'h0, 1'b0, 1'b0, 4'd0, M_NONE, 4'hC, 1'b0, 2'b01);
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        n_checks++; if (mem_req !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL clr_mid_ctl: req %b ready %b want 0 1", mem_req, cmd_ready); end
        n_checks++; if (out_port !== 32'h0) begin n_fail++; $display("FAIL clr_mid_out: got %h want 0", out_port); end
        dones = (cmd_done === 1'b1) ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (cmd_done === 1'b1) dones++;
        end
        n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL clr_mid_nodone: got %0d want 0", dones); end
        xf(S_MDR, 32'h0, 1'b0, 4'd0, M_OUT, 4'hC, lat, err);
        n_checks++; if (out_port !== 32'h0) begin n_fail++; $display("FAIL clr_mid_mdr: got %h want 0", out_port); end
    endtask

    initial begin
        test_reset();
        test_transfer();
        test_alu();
        test_ba();
        test_mem_read();
        test_mem_write();
        test_err();
        test_mul();
        test_clear_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
